// File: rtl/text_console_pkg.sv
// Shared constants and types for the debug text console front end.
// Pure declarations, no logic or latency.
// Used by the console writer and the character-RAM address map.
package text_console_pkg;

  localparam int COLS_DEFAULT = 80;
  localparam int ROWS_DEFAULT = 25;

  localparam logic [7:0] ASCII_SPACE    = 8'h20;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_BS       = 8'h08;
  localparam logic [7:0] ASCII_TAB      = 8'h09;
  localparam logic [7:0] ASCII_PRINT_LO = 8'h20;
  localparam logic [7:0] ASCII_PRINT_HI = 8'h7E;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    CLEAR_ALL  = 2'd1,
    CLEAR_LINE = 2'd2
  } state_t;

  // True for bytes that produce a glyph write.
  function automatic logic is_printable(input logic [7:0] c);
    return (c >= ASCII_PRINT_LO) && (c <= ASCII_PRINT_HI);
  endfunction

endpackage

// File: rtl/text_addr_map.sv
// Maps a logical (row, col) plus the scroll offset to a physical char RAM address.
// Purely combinational, zero latency.
// No flow control; also instantiated by the renderer.
module text_addr_map
  import text_console_pkg::*;
#(
  parameter int COLS = COLS_DEFAULT,
  parameter int ROWS = ROWS_DEFAULT,
  localparam int AW = $clog2(COLS * ROWS),
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS)
) (
  input  logic [RW-1:0] row,
  input  logic [RW-1:0] top_row,
  input  logic [CW-1:0] col,
  output logic [AW-1:0] addr
);

  logic [RW:0] row_sum;
  logic [RW:0] phys_row;

  // Both operands are below ROWS, so one conditional subtract replaces the modulo.
  always_comb begin
    row_sum  = {1'b0, row} + {1'b0, top_row};
    phys_row = row_sum;
    if (row_sum >= (RW+1)'(ROWS)) begin
      phys_row = row_sum - (RW+1)'(ROWS);
    end
    addr = AW'(phys_row) * AW'(COLS) + AW'(col);
  end

endmodule

// File: rtl/text_console_writer.sv
// Byte-stream terminal front end: decodes ASCII, writes glyphs to char RAM, tracks the cursor.
// One cycle from byte acceptance to registered wr_*/cursor outputs; one byte per cycle in IDLE.
// in_ready drops during screen/line clears; optional TAB stops via TEXT_CONSOLE_TAB_EN.
module text_console_writer
  import text_console_pkg::*;
#(
  parameter int COLS = COLS_DEFAULT,
  parameter int ROWS = ROWS_DEFAULT,
  localparam int AW = $clog2(COLS * ROWS),
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic [RW-1:0] top_row,
  output logic [CW-1:0] cursor_col,
  output logic [RW-1:0] cursor_row,
  output logic          cursor_moved
);

  localparam logic [AW-1:0] LAST_CELL = AW'(COLS * ROWS - 1);
  localparam logic [AW-1:0] LAST_COL  = AW'(COLS - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          in_ready_nxt;
  logic          wr_en_nxt;
  logic [AW-1:0] wr_addr_nxt;
  logic [7:0]    wr_data_nxt;
  logic [RW-1:0] top_nxt;
  logic [CW-1:0] col_nxt;
  logic [RW-1:0] row_nxt;
  logic          moved_nxt;
  logic          newline;

  logic [CW-1:0] map_col;
  logic [AW-1:0] map_addr;

  // During a line clear the cursor sits on the bottom row and top_row has already
  // advanced, so the map lands on the old top physical row; only the column differs.
  assign map_col = (state == CLEAR_LINE) ? cnt[CW-1:0] : cursor_col;

  text_addr_map #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_addr_map (
    .row     (cursor_row),
    .top_row (top_row),
    .col     (map_col),
    .addr    (map_addr)
  );

`ifdef TEXT_CONSOLE_TAB_EN
  logic [CW:0] tab_stop;
  // Next multiple of 8 strictly beyond the current column.
  assign tab_stop = {1'b0, cursor_col | CW'(7)} + 1'b1;
`endif

  // Next-state and registered-output decode.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    in_ready_nxt = in_ready;
    wr_en_nxt    = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    top_nxt      = top_row;
    col_nxt      = cursor_col;
    row_nxt      = cursor_row;
    moved_nxt    = 1'b0;
    newline      = 1'b0;

    case (state)
      CLEAR_ALL: begin
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = cnt;
        wr_data_nxt = ASCII_SPACE;
        if (cnt == LAST_CELL) begin
          cnt_nxt      = '0;
          state_nxt    = IDLE;
          in_ready_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      CLEAR_LINE: begin
        wr_en_nxt   = 1'b1;
        wr_addr_nxt = map_addr;
        wr_data_nxt = ASCII_SPACE;
        if (cnt == LAST_COL) begin
          cnt_nxt      = '0;
          state_nxt    = IDLE;
          in_ready_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end

      IDLE: begin
        if (in_valid && in_ready) begin
          if (is_printable(in_data)) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = map_addr;
            wr_data_nxt = in_data;
            if (cursor_col == CW'(COLS - 1)) begin
              newline = 1'b1;
            end else begin
              col_nxt = cursor_col + 1'b1;
            end
          end else if (in_data == ASCII_LF) begin
            newline = 1'b1;
          end else if (in_data == ASCII_CR) begin
            col_nxt = '0;
          end else if (in_data == ASCII_BS) begin
            if (cursor_col != '0) begin
              col_nxt = cursor_col - 1'b1;
            end
          end
`ifdef TEXT_CONSOLE_TAB_EN
          else if (in_data == ASCII_TAB) begin
            if (tab_stop >= (CW+1)'(COLS)) begin
              newline = 1'b1;
            end else begin
              col_nxt = tab_stop[CW-1:0];
            end
          end
`endif

          if (newline) begin
            col_nxt = '0;
            if (cursor_row != RW'(ROWS - 1)) begin
              row_nxt = cursor_row + 1'b1;
            end else begin
              // Scroll by rotating the top pointer; the old top row becomes the
              // new bottom row and is blanked before accepting more input.
              top_nxt      = (top_row == RW'(ROWS - 1)) ? '0 : top_row + 1'b1;
              state_nxt    = CLEAR_LINE;
              cnt_nxt      = '0;
              in_ready_nxt = 1'b0;
            end
          end

          moved_nxt = (col_nxt != cursor_col) || (row_nxt != cursor_row);
        end
      end

      default: begin
        state_nxt    = CLEAR_ALL;
        cnt_nxt      = '0;
        in_ready_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; reset restarts the full-screen clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= CLEAR_ALL;
      cnt          <= '0;
      in_ready     <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      top_row      <= '0;
      cursor_col   <= '0;
      cursor_row   <= '0;
      cursor_moved <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      in_ready     <= in_ready_nxt;
      wr_en        <= wr_en_nxt;
      wr_addr      <= wr_addr_nxt;
      wr_data      <= wr_data_nxt;
      top_row      <= top_nxt;
      cursor_col   <= col_nxt;
      cursor_row   <= row_nxt;
      cursor_moved <= moved_nxt;
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// Self-checking bench for text_console_writer (COLS=80, ROWS=25).
// Table vectors, directed corner sequences and random bytes against a screen-level model.
// Honours TEXT_CONSOLE_TAB_EN in the model the same way as the design build.
`timescale 1ns/1ps
module tb_text_console_writer;

  localparam int COLS = 80;
  localparam int ROWS = 25;
  localparam int AW = $clog2(COLS * ROWS);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [RW-1:0] top_row;
  logic [CW-1:0] cursor_col;
  logic [RW-1:0] cursor_row;
  logic          cursor_moved;

  text_console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .top_row      (top_row),
    .cursor_col   (cursor_col),
    .cursor_row   (cursor_row),
    .cursor_moved (cursor_moved)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: logical cursor and scroll offset.
  int m_row, m_col, m_top;

  typedef struct {
    logic [7:0] b;
    bit         we;
    int         addr;
    int         col;
    int         row;
    bit         mv;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    int bad;
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en",    int'(wr_en), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_col",      int'(cursor_col), 0);
    chk("rst_row",      int'(cursor_row), 0);
    chk("rst_top",      int'(top_row), 0);
    chk("rst_moved",    int'(cursor_moved), 0);
    @(negedge clk);
    reset = 1'b0;
    m_row = 0; m_col = 0; m_top = 0;
    bad = 0;
    for (int i = 0; i < COLS * ROWS; i++) begin
      @(posedge clk);
      #1;
      if (!(wr_en && int'(wr_addr) == i && wr_data == 8'h20 &&
            in_ready == (i == COLS * ROWS - 1))) bad++;
    end
    chk("clear_all_bad_cycles", bad, 0);
    chk("clear_all_ready", int'(in_ready), 1);
    chk("clear_all_col", int'(cursor_col), 0);
    chk("clear_all_row", int'(cursor_row), 0);
  endtask

  // Offer one byte, wait for acceptance, and check the outcome against the model.
  task automatic send(input logic [7:0] b, input bit run_clear, output bit scrolled);
    bit we, nl, mv, rdy;
    int n_col, n_row, n_top, exp_addr, waited, old_top;
    we = 0; nl = 0; scrolled = 0;
    n_col = m_col; n_row = m_row; n_top = m_top;
    exp_addr = ((m_row + m_top) % ROWS) * COLS + m_col;
    if (b >= 8'h20 && b <= 8'h7E) begin
      we = 1;
      if (m_col == COLS - 1) nl = 1; else n_col = m_col + 1;
    end else if (b == 8'h0A) nl = 1;
    else if (b == 8'h0D) n_col = 0;
    else if (b == 8'h08) begin
      if (m_col > 0) n_col = m_col - 1;
    end
`ifdef TEXT_CONSOLE_TAB_EN
    else if (b == 8'h09) begin
      if ((m_col / 8 + 1) * 8 >= COLS) nl = 1; else n_col = (m_col / 8 + 1) * 8;
    end
`endif
    if (nl) begin
      n_col = 0;
      if (m_row < ROWS - 1) n_row = m_row + 1;
      else begin
        scrolled = 1;
        n_top = (m_top + 1) % ROWS;
      end
    end
    mv = (n_col != m_col) || (n_row != m_row);

    in_data  = b;
    in_valid = 1'b1;
    waited   = 0;
    do begin
      rdy = in_ready;
      @(posedge clk);
      #1;
      waited++;
    end while (!rdy && waited < 5000);
    in_valid = 1'b0;
    chk("accept_ready", int'(rdy), 1);
    if (!rdy) return;

    chk("wr_en", int'(wr_en), int'(we));
    if (we) begin
      chk("wr_addr", int'(wr_addr), exp_addr);
      chk("wr_data", int'(wr_data), int'(b));
    end
    chk("cursor_col", int'(cursor_col), n_col);
    chk("cursor_row", int'(cursor_row), n_row);
    chk("top_row", int'(top_row), n_top);
    chk("cursor_moved", int'(cursor_moved), int'(mv));
    chk("in_ready_after", int'(in_ready), int'(!scrolled));

    old_top = m_top;
    m_col = n_col; m_row = n_row; m_top = n_top;

    if (scrolled && run_clear) begin
      for (int i = 0; i < COLS; i++) begin
        @(posedge clk);
        #1;
        chk("clear_line_cell", (wr_en && wr_data == 8'h20) ? int'(wr_addr) : -1,
            old_top * COLS + i);
        chk("clear_line_ready", int'(in_ready), int'(i == COLS - 1));
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit s;
    int r;
    logic [7:0] b;

    tv[0] = '{8'h41, 1, 0,  1, 0, 1};  // 'A'
    tv[1] = '{8'h42, 1, 1,  2, 0, 1};  // 'B'
    tv[2] = '{8'h0D, 0, 0,  0, 0, 1};  // CR from col 2
    tv[3] = '{8'h0D, 0, 0,  0, 0, 0};  // CR at col 0
    tv[4] = '{8'h08, 0, 0,  0, 0, 0};  // BS at col 0
    tv[5] = '{8'h07, 0, 0,  0, 0, 0};  // dropped control byte
    tv[6] = '{8'h43, 1, 0,  1, 0, 1};  // 'C' overwrites cell 0
    tv[7] = '{8'h08, 0, 0,  0, 0, 1};  // BS, no erase
    tv[8] = '{8'h0A, 0, 0,  0, 1, 1};  // LF
    tv[9] = '{8'h44, 1, 80, 1, 1, 1};  // 'D' on row 1

    reset = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    do_reset();

    // Back-to-back table bytes (zero-bubble stream).
    for (int i = 0; i < 10; i++) begin
      send(tv[i].b, 1'b1, s);
      chk("tv_wr_en", int'(wr_en), int'(tv[i].we));
      if (tv[i].we) chk("tv_wr_addr", int'(wr_addr), tv[i].addr);
      chk("tv_col", int'(cursor_col), tv[i].col);
      chk("tv_row", int'(cursor_row), tv[i].row);
      chk("tv_moved", int'(cursor_moved), int'(tv[i].mv));
    end

    // Full row of 'x' from column 0 of row 1, then the wrapped byte.
    send(8'h0D, 1'b1, s);
    for (int i = 0; i < COLS; i++) begin
      send(8'h78, 1'b1, s);
      if (i == COLS - 1) chk("row_last_addr", int'(wr_addr), COLS + COLS - 1);
    end
    chk("wrap_col", int'(cursor_col), 0);
    chk("wrap_row", int'(cursor_row), 2);
    send(8'h79, 1'b1, s);
    chk("wrap_next_addr", int'(wr_addr), 2 * COLS);

    // TAB from column 75.
    send(8'h0D, 1'b1, s);
    for (int i = 0; i < 75; i++) send(8'h71, 1'b1, s);
    send(8'h09, 1'b1, s);
    chk("tab_wr_en", int'(wr_en), 0);
`ifdef TEXT_CONSOLE_TAB_EN
    chk("tab_col", int'(cursor_col), 0);
    chk("tab_row", int'(cursor_row), 3);
    chk("tab_moved", int'(cursor_moved), 1);
`else
    chk("tab_col", int'(cursor_col), 75);
    chk("tab_row", int'(cursor_row), 2);
    chk("tab_moved", int'(cursor_moved), 0);
`endif

    // First scroll: LF on the bottom row.
    while (m_row < ROWS - 1) send(8'h0A, 1'b1, s);
    send(8'h0A, 1'b1, s);
    chk("scroll_flag", int'(s), 1);
    chk("scroll_top", int'(top_row), 1);
    send(8'h5A, 1'b1, s);
    chk("scroll_z_addr", int'(wr_addr), 0);
    chk("scroll_z_en", int'(wr_en), 1);

    // Reset in the middle of a line clear.
    send(8'h0A, 1'b0, s);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("mid_clear_addr", int'(wr_addr), COLS + 4);
    chk("mid_clear_ready", int'(in_ready), 0);
    do_reset();

    // Random byte stream with occasional idle cycles.
    for (int n = 0; n < 2000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      b = 8'($urandom_range(8'h20, 8'h7E));
      else if (r < 78) b = 8'h0A;
      else if (r < 84) b = 8'h0D;
      else if (r < 90) b = 8'h08;
      else if (r < 95) b = 8'h09;
      else             b = 8'($urandom_range(0, 255));
      send(b, 1'b1, s);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
        chk("idle_wr_en", int'(wr_en), 0);
        chk("idle_moved", int'(cursor_moved), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
